// File: rtl/fp32_dot_accum_pkg.sv
// Shared definitions for the FP32 dot-product engine: FP32 constants,
// rounding-mode encodings, FSM states, the latched per-operation config
// and the directed-rounding increment helper used by fp32_mac.
package fp32_dot_accum_pkg;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3f80_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7fc0_0000;
  localparam logic [31:0] FP32_MAX  = 32'h7f7f_ffff;

  localparam logic [1:0] RND_RNE = 2'b00;  // nearest, ties to even
  localparam logic [1:0] RND_RTZ = 2'b01;  // toward zero
  localparam logic [1:0] RND_RDN = 2'b10;  // toward -inf
  localparam logic [1:0] RND_RUP = 2'b11;  // toward +inf

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_e;

  typedef struct packed {
    logic       negate_ab;
    logic [1:0] rnd_mode;
  } cfg_t;

  // 1 when the truncated magnitude must be bumped by one ulp.
  function automatic logic rnd_inc(input logic [1:0] mode, input logic sgn,
                                   input logic lsb, input logic g, input logic st);
    case (mode)
      RND_RNE: rnd_inc = g & (st | lsb);
      RND_RTZ: rnd_inc = 1'b0;
      RND_RDN: rnd_inc = (g | st) & sgn;
      default: rnd_inc = (g | st) & ~sgn;
    endcase
  endfunction

endpackage

// File: rtl/fp32_dot_accum_mac.sv
// fp32_mac: combinational single-rounding FP32 fused multiply-add.
//   r = round( (negate_ab ? -(a*b) : a*b) + (negate_c ? -c : c) )
// Ports: a, b, c (FP32 in), negate_ab, negate_c, rnd_mode (2b), r (FP32 out).
// NaN inputs and invalid ops give the canonical quiet NaN; Inf and
// denormals are handled per IEEE-754.
module fp32_mac
  import fp32_dot_accum_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic        negate_ab,
  input  logic        negate_c,
  input  logic [1:0]  rnd_mode,
  output logic [31:0] r
);

  logic              sp, sc, big_s, sml_s, sgn, inc, sml_st;
  logic              a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, a_zero, b_zero;
  logic [7:0]        ea, eb, ec_f;
  logic [23:0]       ma, mb, mc;
  logic [47:0]       pm;
  logic signed [11:0] pe, ec, e, diff, re;
  logic [6:0]        dsh, lz, s;
  // Fixed-point frame: bit 94 has weight 2^(e-127); 48 zero guard bits
  // at the bottom keep alignment exact or leave only sticky-grade loss.
  logic [96:0]       fp, fc, big, sml, sml_sh, sum, norm;
  logic [30:0]       rnd_pk;

  assign a_nan  = (&a[30:23]) & (|a[22:0]);
  assign b_nan  = (&b[30:23]) & (|b[22:0]);
  assign c_nan  = (&c[30:23]) & (|c[22:0]);
  assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
  assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
  assign c_inf  = (&c[30:23]) & ~(|c[22:0]);
  assign a_zero = ~(|a[30:0]);
  assign b_zero = ~(|b[30:0]);

  assign sp = a[31] ^ b[31] ^ negate_ab;
  assign sc = c[31] ^ negate_c;

  // Denormals use exponent 1 and no hidden bit.
  assign ea   = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
  assign eb   = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
  assign ec_f = (c[30:23] == 8'd0) ? 8'd1 : c[30:23];
  assign ma   = {|a[30:23], a[22:0]};
  assign mb   = {|b[30:23], b[22:0]};
  assign mc   = {|c[30:23], c[22:0]};
  assign pm   = {24'd0, ma} * {24'd0, mb};

  always_comb begin
    // A zero product must not pull the common exponent upward.
    pe = (pm == 48'd0) ? 12'sd1
                       : $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd127;
    ec = $signed({4'd0, ec_f});
    fp = {1'b0, pm, 48'd0};
    fc = {2'b0, mc, 23'd0, 48'd0};
    if (pe >= ec) begin
      big = fp; big_s = sp; sml = fc; sml_s = sc; e = pe; diff = pe - ec;
    end else begin
      big = fc; big_s = sc; sml = fp; sml_s = sp; e = ec; diff = ec - pe;
    end
    dsh       = (diff > 12'sd127) ? 7'd127 : diff[6:0];
    sml_sh    = sml >> dsh;
    sml_st    = ((sml_sh << dsh) != sml);
    sml_sh[0] = sml_sh[0] | sml_st;

    if (big_s == sml_s) begin
      sum = big + sml_sh; sgn = big_s;
    end else if (big >= sml_sh) begin
      sum = big - sml_sh; sgn = big_s;
    end else begin
      sum = sml_sh - big; sgn = sml_s;
    end
    if (sum == 97'd0) sgn = (big_s == sml_s) ? big_s : (rnd_mode == RND_RDN);

    lz = 7'd0;
    for (int i = 0; i < 97; i++) if (sum[i]) lz = 7'(96 - i);
    // Normalize, but never below exponent 1 (denormal result).
    if ($signed({5'd0, lz}) <= e + 12'sd1) s = lz;
    else                                   s = 7'(e + 12'sd1);
    norm = sum << s;
    re   = norm[96] ? (e + 12'sd2 - $signed({5'd0, s})) : 12'sd0;

    inc    = rnd_inc(rnd_mode, sgn, norm[73], norm[72], |norm[71:0]);
    rnd_pk = {re[7:0], norm[95:73]} + {30'd0, inc};

    if (a_nan | b_nan | c_nan | (a_inf & b_zero) | (b_inf & a_zero) |
        ((a_inf | b_inf) & c_inf & (sp != sc)))
      r = FP32_QNAN;
    else if (a_inf | b_inf)   r = {sp, 8'hff, 23'd0};
    else if (c_inf)           r = {sc, 8'hff, 23'd0};
    else if (sum == 97'd0)    r = {sgn, 31'd0};
    else if (re >= 12'sd255) begin
      if ((rnd_mode == RND_RTZ) || (rnd_mode == RND_RDN && !sgn) ||
          (rnd_mode == RND_RUP && sgn))
        r = {sgn, FP32_MAX[30:0]};
      else
        r = {sgn, 8'hff, 23'd0};
    end else                  r = {sgn, rnd_pk};
  end

endmodule

// File: rtl/fp32_dot_accum.sv
// fp32_dot_accum: sequential dot-product engine around fp32_mac.
// Ports: clk, rst_n (async low); start/len/bias/negate_ab/rnd_mode command
// sampled in IDLE; in_valid/in_ready/in_a/in_b operand stream;
// out_valid/out_ready/out_data result; busy (ACCUM or DONE).
// acc <= fp32_mac(a, b, acc) once per accepted pair, one pair per cycle.
module fp32_dot_accum
  import fp32_dot_accum_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      bias,
  input  logic             negate_ab,
  input  logic [1:0]       rnd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy
);

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d, mac_r;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  cfg_t             cfg_q, cfg_d;

  fp32_mac u_mac (
    .a        (in_a),
    .b        (in_b),
    .c        (acc_q),
    .negate_ab(cfg_q.negate_ab),
    .negate_c (1'b0),
    .rnd_mode (cfg_q.rnd_mode),
    .r        (mac_r)
  );

  // Handshake outputs come from registered state only.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = (state_q == ST_DONE) ? acc_q : FP32_ZERO;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    case (state_q)
      ST_IDLE: if (start) begin
        acc_d = bias;
        if (len != '0) begin
          cnt_d           = len;
          cfg_d.negate_ab = negate_ab;
          cfg_d.rnd_mode  = rnd_mode;
          state_d         = ST_ACCUM;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ACCUM: if (in_valid) begin
        acc_d = mac_r;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= FP32_ZERO;
      cnt_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
    end
  end

endmodule

// File: tb/tb_fp32_dot_accum.sv
// Directed bench for fp32_dot_accum with hand-computed FP32 results.
module tb_fp32_dot_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] bias = '0;
  logic        negate_ab = 1'b0;
  logic [1:0]  rnd_mode = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp32_dot_accum #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias),
    .negate_ab(negate_ab), .rnd_mode(rnd_mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [15:0] l, input logic [31:0] bs, input logic ng);
    start = 1'b1; len = l; bias = bs; negate_ab = ng; rnd_mode = 2'b00;
    tick();
    start = 1'b0; len = 16'd9; bias = 32'h4120_0000; negate_ab = ~ng;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0; in_a = 32'h4000_0000; in_b = 32'h4000_0000;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1;
    check_reset_outs("rst");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T1: 1*2 + 0.5*0.5 + 3*1 = 5.25; a pair offered in IDLE must not be taken
    in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4000_0000;
    chk("t1_idle_ready", {31'd0, in_ready}, 32'd0);
    cmd(16'd3, 32'h0000_0000, 1'b0);
    in_valid = 1'b0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    send(32'h3f80_0000, 32'h4000_0000);
    send(32'h3f00_0000, 32'h3f00_0000);
    chk("t1_valid_early", {31'd0, out_valid}, 32'd0);
    send(32'h4040_0000, 32'h3f80_0000);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data", out_data, 32'h40a8_0000);
    chk("t1_ready_done", {31'd0, in_ready}, 32'd0);
    finish_out("t1");

    // T2: len=0 returns bias the next cycle
    cmd(16'd0, 32'h4040_0000, 1'b0);
    chk("t2_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_data", out_data, 32'h4040_0000);
    finish_out("t2");

    // T3: 1 + 2*2 + (-1)*1 = 4 with input bubbles and output stall
    cmd(16'd2, 32'h3f80_0000, 1'b0);
    send(32'h4000_0000, 32'h4000_0000);
    tick();
    chk("t3_bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_bubble_ready", {31'd0, in_ready}, 32'd1);
    send(32'hbf80_0000, 32'h3f80_0000);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_stall_data", out_data, 32'h4080_0000);
      tick();
    end
    chk("t3_data", out_data, 32'h4080_0000);
    finish_out("t3");

    // T4: 5 - 1*2 = 3
    cmd(16'd1, 32'h40a0_0000, 1'b1);
    send(32'h3f80_0000, 32'h4000_0000);
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_data", out_data, 32'h4040_0000);
    finish_out("t4");

    // T5: async reset mid-operation, then 0 + 0.5*0.5 = 0.25
    cmd(16'd3, 32'h0000_0000, 1'b0);
    send(32'h3f80_0000, 32'h4000_0000);
    rst_n = 1'b0;
    #1;
    check_reset_outs("t5_rst");
    tick();
    rst_n = 1'b1;
    tick();
    cmd(16'd1, 32'h0000_0000, 1'b0);
    send(32'h3f00_0000, 32'h3f00_0000);
    chk("t5_data", out_data, 32'h3e80_0000);
    finish_out("t5");

    // T6: start pulse during ACCUM is ignored
    cmd(16'd3, 32'h0000_0000, 1'b0);
    send(32'h3f80_0000, 32'h4000_0000);
    start = 1'b1; len = 16'd7; bias = 32'h4120_0000;
    send(32'h3f00_0000, 32'h3f00_0000);
    start = 1'b0;
    send(32'h4040_0000, 32'h3f80_0000);
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_data", out_data, 32'h40a8_0000);
    finish_out("t6");
    tick();
    chk("t6_still_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
